mdu: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers. It extends the single-cycle MIPS datapath with mult, multu, div, divu, mthi and mtlo. The execute stage launches an operation with a start pulse. The unit holds `busy` for a parametrised latency, then commits the result to HI/LO. It sits beside the ALU, fed by the rs/rt register data. The controller stalls any HI/LO access while `busy` is high.

---
 rtl/mdu.sv | 193 +++++++++++++++++++
 tb/tb_mdu.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state, w_state_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [3:0]       r_op, w_op_n;
  logic [WIDTH-1:0] r_a, w_a_n;
  logic [WIDTH-1:0] r_b, w_b_n;
  logic [WIDTH-1:0] r_hi, w_hi_n;
  logic [WIDTH-1:0] r_lo, w_lo_n;

  logic w_mul_req, w_div_req;
  logic w_mthi_req, w_mtlo_req;
  logic w_done, w_free, w_wr;

  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH-1:0]   w_sdiv, w_udiv;
  logic [WIDTH-1:0]   w_sq, w_sr, w_uq, w_ur;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  always_comb begin
    w_mul_req  = 1'b0;
    w_div_req  = 1'b0;
    w_mthi_req = 1'b0;
    w_mtlo_req = 1'b0;
    unique case (1'b1)
      op == OP_MULT,
      op == OP_MULTU: w_mul_req = 1'b1;
`ifdef MDU_MADD_EN
      op == OP_MADD,
      op == OP_MADDU,
      op == OP_MSUB,
      op == OP_MSUBU: w_mul_req = 1'b1;
`endif
      op == OP_DIV,
      op == OP_DIVU:  w_div_req = 1'b1;
      op == OP_MTHI:  w_mthi_req = 1'b1;
      op == OP_MTLO:  w_mtlo_req = 1'b1;
      default: ;
    endcase
  end

  // The commit edge also frees the unit, allowing back-to-back issue.
  assign w_done = (r_state == S_RUN) && (r_cnt == CW'(1));
  assign w_free = (r_state == S_IDLE) || w_done;

  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} *
                    {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} *
                    {{WIDTH{1'b0}}, r_b};

  // Signed divide via magnitudes; a zero divisor is swapped for 1
  // only to keep the datapath defined, the result is discarded.
  assign w_abs_a = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_abs_b = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_sdiv  = (r_b == '0) ? WIDTH'(1) : w_abs_b;
  assign w_udiv  = (r_b == '0) ? WIDTH'(1) : r_b;
  assign w_uq    = r_a / w_udiv;
  assign w_ur    = r_a % w_udiv;

  always_comb begin
    w_sq = w_abs_a / w_sdiv;
    w_sr = w_abs_a % w_sdiv;
    if (r_a[WIDTH-1] ^ r_b[WIDTH-1]) w_sq = -w_sq;
    if (r_a[WIDTH-1]) w_sr = -w_sr;
  end

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_wr     = 1'b1;
    case (r_op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        w_res_hi = w_sr;
        w_res_lo = w_sq;
        w_wr     = (r_b != '0);
      end
      OP_DIVU: begin
        w_res_hi = w_ur;
        w_res_lo = w_uq;
        w_wr     = (r_b != '0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:
        {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s;
      OP_MADDU:
        {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_u;
      OP_MSUB:
        {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod_s;
      OP_MSUBU:
        {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod_u;
`endif
      default: w_wr = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_op_n    = r_op;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    if (w_done) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
      if (w_wr) begin
        w_hi_n = w_res_hi;
        w_lo_n = w_res_lo;
      end
    end else if (r_state == S_RUN) begin
      w_cnt_n = r_cnt - CW'(1);
    end
    // Moves are applied last so they win over a same-edge commit.
    if (start && w_free) begin
      if (w_mthi_req) w_hi_n = operand1;
      if (w_mtlo_req) w_lo_n = operand1;
      if (w_mul_req || w_div_req) begin
        w_state_n = S_RUN;
        w_cnt_n   = w_div_req ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        w_op_n    = op;
        w_a_n     = operand1;
        w_b_n     = operand2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_op    <= w_op_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu against an arithmetic HI/LO model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total;
  int bad;

  logic [W-1:0] mhi;
  logic [W-1:0] mlo;

  mdu #(
    .WIDTH     (W),
    .MUL_CYCLES(MULN),
    .DIV_CYCLES(DIVN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand1(operand1),
    .operand2(operand2),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected HI/LO after an op and its busy length, from plain arithmetic.
  task automatic model(input logic [3:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output logic [W-1:0] eh,
                       output logic [W-1:0] el,
                       output int n);
    longint sa, sb;
    logic [63:0] ua, ub, acc, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {mhi, mlo};
    eh  = mhi;
    el  = mlo;
    n   = 0;
    case (o)
      4'd1: begin p = sa * sb; {eh, el} = p; n = MULN; end
      4'd2: begin p = ua * ub; {eh, el} = p; n = MULN; end
      4'd3: begin
        n = DIVN;
        if (b != 0) begin
          p  = sa / sb; el = p[31:0];
          p  = sa % sb; eh = p[31:0];
        end
      end
      4'd4: begin
        n = DIVN;
        if (b != 0) begin
          p  = ua / ub; el = p[31:0];
          p  = ua % ub; eh = p[31:0];
        end
      end
      4'd5: eh = a;
      4'd6: el = a;
`ifdef MDU_MADD_EN
      4'd7:  begin p = acc + 64'(sa * sb); {eh, el} = p; n = MULN; end
      4'd8:  begin p = acc + ua * ub; {eh, el} = p; n = MULN; end
      4'd9:  begin p = acc - 64'(sa * sb); {eh, el} = p; n = MULN; end
      4'd10: begin p = acc - ua * ub; {eh, el} = p; n = MULN; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, measure busy length and check the committed HI/LO.
  task automatic run_op(input logic [3:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input string name);
    logic [W-1:0] eh, el;
    int n, cnt;
    model(o, a, b, eh, el, n);
    @(negedge clk);
    start = 1'b1; op = o; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom);
    operand1 = $urandom; operand2 = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      total++;
      if (hi !== mhi || lo !== mlo) begin
        bad++;
        $display("FAIL %s_hold: got %h_%h want %h_%h",
                 name, hi, lo, mhi, mlo);
      end
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt != n) begin
      bad++;
      $display("FAIL %s_busy: got %0d cycles want %0d", name, cnt, n);
    end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL %s: got %h_%h want %h_%h", name, hi, lo, eh, el);
    end
    mhi = eh;
    mlo = el;
  endtask

  task automatic lit(input string name,
                     input logic [W-1:0] eh,
                     input logic [W-1:0] el);
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL %s_lit: got %h_%h want %h_%h",
               name, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL reset: got b=%b %h_%h want b=0 0_0", busy, hi, lo);
    end
    mhi = '0; mlo = '0;
    @(negedge clk);
    start = 1'b1; op = 4'd1; operand1 = 3; operand2 = 4;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL abort: got b=%b %h_%h want b=0 0_0", busy, hi, lo);
    end
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL no_commit: got b=%b %h_%h want 0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, "mult");
    lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    lit("multu", 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_op(4'd3, -32'sd7, 32'd2, "div");
    lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd2, "divu");
    lit("divu", 32'd1, 32'd3);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    lit("div_ovf", 32'd0, 32'h8000_0000);
  endtask

  task automatic test_divzero();
    run_op(4'd5, 32'h11, 32'd0, "mthi");
    run_op(4'd6, 32'h22, 32'd0, "mtlo");
    run_op(4'd3, 32'd5, 32'd0, "div0");
    lit("div0", 32'h11, 32'h22);
  endtask

  task automatic test_busy_start();
    int cnt;
    @(negedge clk);
    start = 1'b1; op = 4'd1; operand1 = 2; operand2 = 3;
    @(posedge clk); #1;
    start = 1'b0; operand1 = $urandom; operand2 = $urandom;
    @(negedge clk);
    start = 1'b1; op = 4'd5; operand1 = 32'h99;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; operand1 = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt != MULN - 1) begin
      bad++;
      $display("FAIL ign_busy: got %0d want %0d", cnt, MULN - 1);
    end
    lit("ignore_start", 32'd0, 32'd6);
    mhi = 32'd0; mlo = 32'd6;
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    start = 1'b1; op = 4'd1; operand1 = 2; operand2 = 3;
    @(posedge clk); #1 start = 1'b0;
    repeat (MULN - 1) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'd2; operand1 = 4; operand2 = 5;
    @(posedge clk); #1 start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    lit("b2b_first", 32'd0, 32'd6);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt != MULN) begin
      bad++;
      $display("FAIL b2b_len: got %0d want %0d", cnt, MULN);
    end
    lit("b2b_second", 32'd0, 32'd20);
    mhi = 32'd0; mlo = 32'd20;
  endtask

  task automatic test_accum();
    run_op(4'd5, 32'd0, 32'd0, "acc_hi");
    run_op(4'd6, 32'd5, 32'd0, "acc_lo");
`ifdef MDU_MADD_EN
    run_op(4'd7, 32'd2, 32'd3, "madd");
    lit("madd", 32'd0, 32'd11);
    run_op(4'd10, 32'd1, 32'd12, "msubu");
    lit("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    run_op(4'd7, 32'd2, 32'd3, "op7_none");
    lit("op7_none", 32'd0, 32'd5);
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [3:0] o;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(o, a, b, "rand");
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; op = '0;
    operand1 = '0; operand2 = '0;
    mhi = '0; mlo = '0;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_busy_start();
    test_back_to_back();
    test_accum();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
